delay_flow_ctrl: RTL
====================

// Module: delay_flow_ctrl
// PURPOSE
//  Flow controller for an external enable-gated delay chain of depth DELAY (all stages shift together on en).
//  - Adds valid/ready handshakes on both sides of the chain.
//  - Tracks per-stage valid bits in a shadow register and drives the chain's en.
//  - Sequences a flush that drains all in-flight samples.
//  - Sits between the sample producer and consumer; the data path itself stays in the chain instance.
// PARAMETERS
//  DELAY   2   chain depth in stages, >=1; must equal the depth of the attached chain
//  OCC_W   $clog2(DELAY+1)   occupancy counter width (derived, do not override)
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_vld      in   1      upstream sample valid (data presented on chain input)
//  in_rdy      out  1      upstream ready; accept = in_vld & in_rdy
//  out_vld     out  1      chain output stage holds a valid sample
//  dn_rdy      in   1      downstream ready; emit = out_vld & dn_rdy
//  del_en      out  1      shift enable to the delay chain
//  flush_req   in   1      one-cycle request to drain the chain
//  flush_done  out  1      one-cycle pulse: flush complete, chain empty
//  busy        out  1      state != IDLE
//  occ         out  OCC_W  number of valid samples in chain, 0..DELAY
// BEHAVIOUR
//  - Shadow v[DELAY:1]. Output out_vld = v[DELAY]. adv = ~v[DELAY] | dn_rdy. del_en = adv.
//  - On adv: v[1] <= ins, v[i+1] <= v[i]. ins = in_vld & in_rdy. Without adv, v holds.
//  - in_rdy = adv & (state != FLUSH). This is combinational, with no register in the ready path.
//  - Latency: a sample accepted at cycle t is at the output (out_vld=1) at t+DELAY if adv held every cycle.
//  - Bubbles advance with the chain and are not collapsed. A full chain stalls only while out_vld & ~dn_rdy.
//  - occ <= occ + accept - emit. Simultaneous accept and emit leaves occ unchanged. occ never exceeds DELAY or wraps below 0.
//  - FSM states: IDLE, RUN, FLUSH.
//    - IDLE -> RUN on accept (without flush_req).
//    - RUN -> IDLE when occ_next == 0.
//    - IDLE/RUN -> FLUSH on flush_req.
//    - FLUSH -> IDLE when occ_next == 0; flush_done=1 on that transition cycle's next clock (registered pulse).
//  - flush_req in IDLE with an empty chain: enter FLUSH, flush_done pulses one cycle later.
//  - flush_req in the same cycle as an accept: the sample is accepted and is included in the flush.
//  - flush_req while already in FLUSH is ignored.
//  - During FLUSH, in_rdy=0. The chain still advances per adv, inserting bubbles. Downstream backpressure lengthens the flush; no sample is dropped.
//  - Reset (async assert, any time, incl. mid-flush):
//    - v=0, occ=0, state=IDLE.
//    - out_vld=0, flush_done=0, busy=0.
//    - in_rdy=1 and del_en=1 (combinational from the reset state).
//    - Chain data is unreset and treated as invalid.
// CONFIGURATION
//  DELAY_FLOW_STATS_EN defined:
//  - Adds output stall_cnt [15:0].
//  - Counts cycles with out_vld & ~dn_rdy.
//  - Saturates at 16'hFFFF. Reset value 0. Cleared on a flush_done cycle.
//  DELAY_FLOW_STATS_EN not defined: no stall_cnt port and no counter logic.
//  Handshake behaviour is identical either way.
// TESTING
//  1. DELAY=2, dn_rdy=1, in_vld=1 for 5 cycles from t0 -> out_vld at t0+2..t0+6; occ=2 steady; in_rdy=1 throughout.
//  2. DELAY=2, chain full, dn_rdy=0 for 3 cycles -> del_en=0, in_rdy=0, occ=2 held. Release -> both samples emitted in order, none lost or duplicated.
//  3. Three samples in flight, flush_req pulse with dn_rdy=1 -> in_rdy=0 from next cycle; out_vld for 3 samples; flush_done one pulse when occ hits 0; busy drops.
//  4. Flush in IDLE with an empty chain -> flush_done exactly 1 cycle after FLUSH entry. flush_req in the same cycle as an accept -> that sample emitted before flush_done.
//  5. rst_n low mid-flush with occ=2 -> out_vld=0, occ=0, busy=0 immediately (async). After release, first accepted sample appears after DELAY cycles.
//  6. With DELAY_FLOW_STATS_EN: 4 stall cycles -> stall_cnt=4, then cleared at flush_done. Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/delay_flow_ctrl.sv
// rtl/delay_flow_ctrl.sv - valid/ready flow controller for an enable-gated delay chain
//
// Wraps an external delay chain of depth DELAY whose stages all shift together on
// del_en. A shadow register tracks which stages hold valid samples, handshakes are
// added on both sides, and a flush sequence drains every in-flight sample.
//
// Optional feature macro: DELAY_FLOW_STATS_EN (adds the stall_cnt output).
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_vld     in   1      upstream sample valid
//   in_rdy     out  1      upstream ready (combinational)
//   out_vld    out  1      chain output stage holds a valid sample
//   dn_rdy     in   1      downstream ready
//   del_en     out  1      shift enable to the delay chain
//   flush_req  in   1      one-cycle drain request
//   flush_done out  1      one-cycle pulse after the chain has drained
//   busy       out  1      controller not idle
//   occ        out  OCC_W  number of valid samples in the chain
//   stall_cnt  out  16     cycles with out_vld & ~dn_rdy (DELAY_FLOW_STATS_EN only)

module delay_flow_ctrl #(
   parameter int DELAY = 2,
   parameter int OCC_W = $clog2(DELAY + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic             out_vld,
   input  logic             dn_rdy,
   output logic             del_en,
   input  logic             flush_req,
   output logic             flush_done,
   output logic             busy,
`ifdef DELAY_FLOW_STATS_EN
   output logic [OCC_W-1:0] occ,
   output logic [15:0]      stall_cnt
`else
   output logic [OCC_W-1:0] occ
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [DELAY-1:0] v_q, v_d;         // bit i = stage i+1
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             flush_done_q, flush_done_d;

   logic adv;
   logic accept;
   logic emit;

   // The chain may shift whenever its last stage is empty or is being drained.
   assign adv     = ~v_q[DELAY-1] | dn_rdy;
   assign in_rdy  = adv & (state_q != FLUSH);
   assign accept  = in_vld & in_rdy;
   assign emit    = v_q[DELAY-1] & dn_rdy;
   assign out_vld = v_q[DELAY-1];
   assign del_en  = adv;

   assign occ        = occ_q;
   assign busy       = (state_q != IDLE);
   assign flush_done = flush_done_q;

   always_comb begin
      v_d = v_q;
      if (adv) begin
         v_d[0] = accept;
         for (int i = 1; i < DELAY; i++) begin
            v_d[i] = v_q[i-1];
         end
      end
   end

   // accept and emit are mutually bounded by the shadow bits, so occ stays in 0..DELAY.
   assign occ_d = occ_q + OCC_W'(accept) - OCC_W'(emit);

   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d = FLUSH;
            end else if (accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush_req) begin
               state_d = FLUSH;
            end else if (occ_d == '0) begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (occ_d == '0) begin
               state_d      = IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         v_q          <= '0;
         occ_q        <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         v_q          <= v_d;
         occ_q        <= occ_d;
         flush_done_q <= flush_done_d;
      end
   end

`ifdef DELAY_FLOW_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (flush_done_q) begin
         stall_cnt_d = '0;
      end else if (out_vld && !dn_rdy && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
